board_mem_arbiter: RTL and testbench
====================================

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the board RAM word address width (64x32 board).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the board RAM word width (packed cells).
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, meaning the maximum number of consecutive locked grants to the update engine.
REQ-004 The block SHALL have port: clk  in  1  sole clock; all logic on the rising edge.
REQ-005 The block SHALL have port: reset  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have ports: disp_req in 1, disp_addr in ADDR_W, disp_gnt out 1, disp_rvalid out 1, disp_rdata out DATA_W  display read port, read-only.
REQ-007 The block SHALL have ports: upd_req in 1, upd_we in 1, upd_lock in 1, upd_addr in ADDR_W, upd_wdata in DATA_W, upd_gnt out 1, upd_rvalid out 1, upd_rdata out DATA_W  update-engine read/write port.
REQ-008 The block SHALL have ports: ld_req in 1, ld_addr in ADDR_W, ld_wdata in DATA_W, ld_gnt out 1  init/loader port, write-only.
REQ-009 The block SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W  single-port synchronous RAM, read data one cycle after mem_en with mem_we=0.
REQ-010 The block SHALL have port: owner out 2  registered ID of the last granted requester (0 none, 1 disp, 2 upd, 3 ld).

Function
REQ-011 A requester SHALL hold req, addr, we and wdata stable until its gnt is sampled high; each gnt cycle is exactly one access.
REQ-012 At most one gnt SHALL be high per cycle; gnt is combinational from current req and registered arbiter state.
REQ-013 In a gnt cycle, mem_en=1 and mem_addr/mem_we/mem_wdata SHALL equal the granted requester's signals (disp: we=0; ld: we=1); with no gnt, mem_en=0 and mem_we=0.
REQ-014 Priority SHALL be: disp_req always wins; otherwise the state machine picks between upd and ld.
REQ-015 The state machine SHALL have states ARB and LOCKED.
REQ-016 In ARB, upd and ld both requesting SHALL be resolved by a 1-bit round-robin pointer, which toggles to the other requester after each upd or ld grant.
REQ-017 ARB SHALL go to LOCKED on an upd grant with upd_lock=1, loading the lock counter with 1.
REQ-018 In LOCKED, upd_req SHALL beat ld_req regardless of the pointer; each upd grant increments the lock counter.
REQ-019 LOCKED SHALL return to ARB on an upd grant with upd_lock=0, or on the grant that brings the lock counter to LOCK_MAX; on the forced exit the pointer SHALL favour ld.
REQ-020 In LOCKED, upd_lock=0 with no upd_req SHALL return to ARB in the next cycle.
REQ-021 Display pre-emption in LOCKED SHALL NOT advance the lock counter or exit LOCKED.
REQ-022 disp_rvalid / upd_rvalid SHALL pulse exactly one cycle after a read grant to that port, with its rdata equal to mem_rdata in that cycle; no pulse for writes.
REQ-023 disp_rdata and upd_rdata SHALL hold their last valid value when rvalid is low.
REQ-024 owner SHALL update every cycle to the ID granted in the previous cycle (0 if none).
REQ-025 The lock counter SHALL be ceil(log2(LOCK_MAX+1)) bits and never wrap.

Reset
REQ-026 On reset: state ARB, pointer favours upd, lock counter 0, owner 0, both rvalid 0, both rdata 0.
REQ-027 A read granted in the cycle reset is asserted SHALL NOT produce an rvalid after reset.
REQ-028 gnt outputs SHALL be 0 and mem_en SHALL be 0 in any cycle where reset is high.

Structure
REQ-029 Owner IDs, state encodings and ADDR_W/DATA_W defaults SHALL live in the shared package conway_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the 2-way round-robin picker is inline.

Verification
REQ-031 disp_req and upd_req (read, addr 0x041) together -> disp_gnt=1, upd_gnt=0; next cycle upd_gnt=1 and mem_addr=0x041; disp_rvalid one cycle after its grant.
REQ-032 upd_req and ld_req held 6 cycles in ARB after reset -> grants alternate upd, ld, upd, ld, upd, ld.
REQ-033 upd_lock=1 with upd_req and ld_req held -> 16 consecutive upd grants, ld grant on cycle 17, owner sequence 2x16 then 3.
REQ-034 ld write 0xA5 to addr 0x7FF, then upd read of 0x7FF -> upd_rvalid pulse with upd_rdata=0xA5 one cycle after upd_gnt.
REQ-035 reset asserted in the cycle of an upd read grant -> upd_rvalid stays 0, owner=0, state ARB after reset.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared definitions for the Conway board datapath: board RAM geometry,
// requester IDs reported on the arbiter's owner output, and arbiter states.
package conway_pkg;

  localparam int BOARD_ADDR_W = 11;  // 64x32 cells
  localparam int BOARD_DATA_W = 8;   // packed cells per word

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_DISP = 2'd1;
  localparam logic [1:0] OWNER_UPD  = 2'd2;
  localparam logic [1:0] OWNER_LD   = 2'd3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/board_mem_arbiter.sv
// Three-port arbiter in front of the single-port board RAM: display reads
// always win, update engine and loader share the rest with optional locking.
module board_mem_arbiter
  import conway_pkg::*;
#(
  parameter int ADDR_W   = BOARD_ADDR_W,
  parameter int DATA_W   = BOARD_DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,

  input  logic              upd_req,
  input  logic              upd_we,
  input  logic              upd_lock,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wdata,
  output logic              upd_gnt,
  output logic              upd_rvalid,
  output logic [DATA_W-1:0] upd_rdata,

  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [1:0]        owner
);

  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  arb_state_t        state, state_d;
  logic              rr_ld, rr_ld_d;   // 1: ld wins an upd/ld tie in ARB
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_d;
  logic [1:0]        owner_d;
  logic [DATA_W-1:0] disp_rdata_q, upd_rdata_q;

  // Grant selection. Gating with reset keeps a read issued during reset from
  // ever reaching the RAM, so no stale rvalid can appear afterwards.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    disp_gnt = 1'b0;
    upd_gnt  = 1'b0;
    ld_gnt   = 1'b0;
    if (!reset) begin
      if (disp_req) begin
        disp_gnt = 1'b1;
      end else if (state == LOCKED) begin
        if (upd_req)     upd_gnt = 1'b1;
        else if (ld_req) ld_gnt  = 1'b1;
      end else if (upd_req && ld_req) begin
        if (rr_ld) ld_gnt  = 1'b1;
        else       upd_gnt = 1'b1;
      end else if (upd_req) begin
        upd_gnt = 1'b1;
      end else if (ld_req) begin
        ld_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = disp_gnt | upd_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWNER_NONE;
    if (disp_gnt) begin
      mem_addr = disp_addr;
      owner_d  = OWNER_DISP;
    end else if (upd_gnt) begin
      mem_we    = upd_we;
      mem_addr  = upd_addr;
      mem_wdata = upd_wdata;
      owner_d   = OWNER_UPD;
    end else if (ld_gnt) begin
      mem_we    = 1'b1;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      owner_d   = OWNER_LD;
    end
  end

  // Next state. Display pre-emption produces no upd grant, so it leaves the
  // lock counter and the LOCKED state untouched.
  always_comb begin
    state_d    = state;
    lock_cnt_d = lock_cnt;
    rr_ld_d    = rr_ld;
    if (upd_gnt) rr_ld_d = 1'b1;
    if (ld_gnt)  rr_ld_d = 1'b0;

    if (state == ARB) begin
      if (upd_gnt && upd_lock && LOCK_MAX > 1) begin
        state_d    = LOCKED;
        lock_cnt_d = LOCK_W'(1);
      end
    end else begin
      if (upd_gnt) begin
        if (!upd_lock || lock_cnt >= LOCK_LAST) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt + LOCK_W'(1);
        end
      end else if (!upd_req && !upd_lock) begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state        <= ARB;
      rr_ld        <= 1'b0;
      lock_cnt     <= '0;
      owner        <= OWNER_NONE;
      disp_rvalid  <= 1'b0;
      upd_rvalid   <= 1'b0;
      disp_rdata_q <= '0;
      upd_rdata_q  <= '0;
    end else begin
      state       <= state_d;
      rr_ld       <= rr_ld_d;
      lock_cnt    <= lock_cnt_d;
      owner       <= owner_d;
      disp_rvalid <= disp_gnt;
      upd_rvalid  <= upd_gnt & ~upd_we;
      if (disp_rvalid) disp_rdata_q <= mem_rdata;
      if (upd_rvalid)  upd_rdata_q  <= mem_rdata;
    end
  end

  // RAM data is only valid during the rvalid cycle; the holding register
  // presents it again afterwards.
  assign disp_rdata = disp_rvalid ? mem_rdata : disp_rdata_q;
  assign upd_rdata  = upd_rvalid  ? mem_rdata : upd_rdata_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a cycle table of grants/owner/rvalid
// plus hand sequences for alternation, lock limit, RAM readback and reset.
module tb_board_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] DISP_ADDR = 11'h010;
  localparam logic [ADDR_W-1:0] UPD_ADDR  = 11'h041;
  localparam logic [ADDR_W-1:0] LD_ADDR   = 11'h123;
  localparam logic [DATA_W-1:0] UPD_WDATA = 8'h3C;
  localparam logic [DATA_W-1:0] LD_WDATA  = 8'h5A;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_req, upd_req, upd_we, upd_lock, ld_req;
  logic [ADDR_W-1:0] disp_addr, upd_addr, ld_addr;
  logic [DATA_W-1:0] upd_wdata, ld_wdata;
  logic              disp_gnt, disp_rvalid, upd_gnt, upd_rvalid, ld_gnt;
  logic [DATA_W-1:0] disp_rdata, upd_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        owner;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  board_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .upd_req(upd_req), .upd_we(upd_we), .upd_lock(upd_lock),
    .upd_addr(upd_addr), .upd_wdata(upd_wdata), .upd_gnt(upd_gnt),
    .upd_rvalid(upd_rvalid), .upd_rdata(upd_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // Synchronous single-port RAM, read data one cycle after a read enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       dr, ur, uwe, ulk, lr;
    logic [2:0] gnt;    // {disp, upd, ld}
    logic [1:0] owner;
    logic [1:0] rv;     // {disp_rvalid, upd_rvalid}
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dr, input logic ur, input logic uwe,
                       input logic ulk, input logic lr);
    disp_req = dr;
    upd_req  = ur;
    upd_we   = uwe;
    upd_lock = ulk;
    ld_req   = lr;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]        g;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;

    disp_addr = DISP_ADDR;
    upd_addr  = UPD_ADDR;
    ld_addr   = LD_ADDR;
    upd_wdata = UPD_WDATA;
    ld_wdata  = LD_WDATA;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    //            dr    ur    uwe   ulk   lr    gnt     owner  rv
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 2'd0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 2'd1, 2'b10};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'd2, 2'b01};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 2'd3, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'd2, 2'b01};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 2'd3, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'b00};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 2'b00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2'd0, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 2'd3, 2'b00};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 2'd2, 2'b01};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 2'd1, 2'b10};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd2, 2'b01};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'd0, 2'b00};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 2'd3, 2'b00};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 2'd2, 2'b01};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 2'd2, 2'b01};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 2'd2, 2'b01};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'd3, 2'b00};

    // Reset state, with requests pending during reset.
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    check("rst_gnts",   {29'd0, disp_gnt, upd_gnt, ld_gnt}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_owner",  {30'd0, owner}, 32'd0);
    check("rst_rvalid", {30'd0, disp_rvalid, upd_rvalid}, 32'd0);
    check("rst_rdata",  {16'd0, disp_rdata, upd_rdata}, 32'd0);
    tick();
    reset = 1'b0;

    // Cycle table.
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].dr, tbl[i].ur, tbl[i].uwe, tbl[i].ulk, tbl[i].lr);
      #2;
      g         = tbl[i].gnt;
      exp_we    = g[0] | (g[1] & tbl[i].uwe);
      exp_addr  = g[2] ? DISP_ADDR : g[1] ? UPD_ADDR : g[0] ? LD_ADDR : '0;
      exp_wdata = g[1] ? UPD_WDATA : LD_WDATA;
      check($sformatf("tbl%0d_gnt", i), {29'd0, disp_gnt, upd_gnt, ld_gnt}, {29'd0, g});
      check($sformatf("tbl%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].owner});
      check($sformatf("tbl%0d_rvalid", i), {30'd0, disp_rvalid, upd_rvalid},
            {30'd0, tbl[i].rv});
      check($sformatf("tbl%0d_mem_en", i), {31'd0, mem_en}, {31'd0, |g});
      check($sformatf("tbl%0d_mem_we", i), {31'd0, mem_we}, {31'd0, exp_we});
      if (|g) check($sformatf("tbl%0d_mem_addr", i), {21'd0, mem_addr}, {21'd0, exp_addr});
      if (exp_we) check($sformatf("tbl%0d_mem_wdata", i), {24'd0, mem_wdata}, {24'd0, exp_wdata});
      tick();
    end

    // Round-robin alternation from reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      #2;
      check($sformatf("rr%0d_upd_gnt", i), {31'd0, upd_gnt}, {31'd0, (i % 2) == 0});
      check($sformatf("rr%0d_ld_gnt", i),  {31'd0, ld_gnt},  {31'd0, (i % 2) == 1});
      tick();
    end

    // Lock limit: 16 upd grants, then ld.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      check($sformatf("lock%0d_upd_gnt", i), {31'd0, upd_gnt}, {31'd0, i < 16});
      check($sformatf("lock%0d_ld_gnt", i),  {31'd0, ld_gnt},  {31'd0, i == 16});
      if (i > 0) check($sformatf("lock%0d_owner", i), {30'd0, owner}, 32'd2);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("lock_end_owner", {30'd0, owner}, 32'd3);
    tick();

    // Loader write then update read of the top address.
    do_reset();
    ld_addr  = 11'h7FF;
    ld_wdata = 8'hA5;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    check("ram_ld_gnt", {31'd0, ld_gnt}, 32'd1);
    tick();
    upd_addr = 11'h7FF;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check("ram_upd_gnt", {31'd0, upd_gnt}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check("ram_upd_rvalid", {31'd0, upd_rvalid}, 32'd1);
    check("ram_upd_rdata",  {24'd0, upd_rdata}, 32'h0000_00A5);
    tick();
    #2;
    check("ram_rvalid_drop", {31'd0, upd_rvalid}, 32'd0);
    check("ram_rdata_hold",  {24'd0, upd_rdata}, 32'h0000_00A5);
    tick();

    // Reset in the cycle of an update read, while LOCKED.
    upd_addr = UPD_ADDR;
    ld_addr  = LD_ADDR;
    ld_wdata = LD_WDATA;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    #2;
    check("rstg_upd_gnt", {31'd0, upd_gnt}, 32'd0);
    check("rstg_mem_en",  {31'd0, mem_en}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    check("rstg_upd_rvalid", {31'd0, upd_rvalid}, 32'd0);
    check("rstg_owner",      {30'd0, owner}, 32'd0);
    check("rstg_upd_rdata",  {24'd0, upd_rdata}, 32'd0);
    check("rstg_arb_upd",    {31'd0, upd_gnt}, 32'd1);
    tick();
    #2;
    check("rstg_arb_ld",     {31'd0, ld_gnt}, 32'd1);
    check("rstg_owner_upd",  {30'd0, owner}, 32'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
